// File: rtl/dccm_lsu.sv
// Load/store unit in front of a word-wide DCCM. Performs sign/zero-extended sub-word
// loads, word stores and read-modify-write sub-word stores, one request at a time.
module dccm_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_resp_rdata,
    output logic        o_dccm_rd_en,
    output logic [31:0] o_dccm_rd_addr,
    input  logic [31:0] i_dccm_rd_data,
    output logic        o_dccm_wr_en,
    output logic [31:0] o_dccm_wr_addr,
    output logic [31:0] o_dccm_wr_data
);

    typedef enum logic [2:0] {StIdle, StRd, StLdCap, StRmwWr, StWr} state_e;

    state_e      r_state;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_merge;
    logic        w_rd_en;
    logic        w_wr_en;

    // Alignment check on the live request, used only in the accept cycle.
    always_comb begin
        w_misaligned = 1'b1;
        case (i_req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = i_req_addr[0];
            2'b10:   w_misaligned = |i_req_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned DCCM word for loads.
    always_comb begin
        w_byte = i_dccm_rd_data[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = i_dccm_rd_data[7:0];
            2'b01:   w_byte = i_dccm_rd_data[15:8];
            2'b10:   w_byte = i_dccm_rd_data[23:16];
            default: w_byte = i_dccm_rd_data[31:24];
        endcase
        w_half = r_addr[1] ? i_dccm_rd_data[31:16] : i_dccm_rd_data[15:0];
        case (r_size)
            2'b00:   w_ld_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_ld_data = i_dccm_rd_data;
        endcase
    end

    // Read-modify-write merge: replace the addressed lane of the read word.
    always_comb begin
        w_merge = i_dccm_rd_data;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merge[7:0]   = r_wdata[7:0];
                2'b01:   w_merge[15:8]  = r_wdata[7:0];
                2'b10:   w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_we       <= i_req_we;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        if (w_misaligned) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (i_req_we && i_req_size == 2'b10) begin
                            r_state <= StWr;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            r_state <= StRd;
                        end
                    end
                end
                StRd: r_state <= r_we ? StRmwWr : StLdCap;
                StLdCap: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_ld_data;
                end
                StRmwWr, StWr: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b1;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // DCCM strobes decode from state; gated by reset so nothing leaks while it is held.
    assign w_rd_en = (r_state == StRd) & ~i_rst;
    assign w_wr_en = ((r_state == StWr) | (r_state == StRmwWr)) & ~i_rst;

    assign o_req_ready    = (r_state == StIdle) & ~i_rst;
    assign o_resp_valid   = r_resp_valid & ~i_rst;
    assign o_resp_err     = r_resp_err & ~i_rst;
    assign o_resp_rdata   = i_rst ? 32'h0 : r_resp_rdata;
    assign o_dccm_rd_en   = w_rd_en;
    assign o_dccm_rd_addr = w_rd_en ? {2'b00, r_addr[31:2]} : 32'h0;
    assign o_dccm_wr_en   = w_wr_en;
    assign o_dccm_wr_addr = w_wr_en ? {2'b00, r_addr[31:2]} : 32'h0;
    assign o_dccm_wr_data = !w_wr_en ? 32'h0 : ((r_state == StWr) ? r_wdata : w_merge);

endmodule

// File: tb/tb_dccm_lsu.sv
// Randomized self-checking bench for dccm_lsu with a word-array reference memory.
module tb_dccm_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        rd_en, wr_en;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [31:0] rd_data = 32'h0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'h0;
    logic [31:0] bd_val = 32'h0;
    bit          done = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dccm_lsu dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_err     (resp_err),
        .o_resp_rdata   (resp_rdata),
        .o_dccm_rd_en   (rd_en),
        .o_dccm_rd_addr (rd_addr),
        .i_dccm_rd_data (rd_data),
        .o_dccm_wr_en   (wr_en),
        .o_dccm_wr_addr (wr_addr),
        .o_dccm_wr_data (wr_data)
    );

    // DCCM model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (rd_en) rd_data <= mem[rd_addr[3:0]];
        if (wr_en) mem[wr_addr[3:0]] <= wr_data;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol invariants sampled every cycle.
    always @(negedge clk) begin
        if (!done && !rst) begin
            chk_eq("both_strobes", {31'b0, rd_en & wr_en}, 32'h0);
            if (!rd_en) chk_eq("rd_addr_idle", rd_addr, 32'h0);
            if (!wr_en) chk_eq("wr_addr_idle", wr_addr | wr_data, 32'h0);
        end
    end

    function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (addr % 2) != 0;
        if (size == 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input bit uns, input logic [31:0] addr);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(addr % 4);
            v = (word >> sh) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = 16 * int'((addr / 2) % 2);
            v = (word >> sh) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (size == 2'd2) return wd;
        sh = (size == 2'd0) ? 8 * int'(addr % 4) : 16 * int'((addr / 2) % 2);
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic bd_write(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic scramble_fields();
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    // One complete transaction, checked against the reference memory.
    task automatic do_txn(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        bit          mis;
        int          exp_lat, exp_rd, exp_wr, lat, nrd, nwr;
        logic [3:0]  idx;
        logic [31:0] exp_rdata, exp_wdata;
        mis = ref_mis(size, addr);
        idx = addr[5:2];
        exp_rdata = 32'h0;
        exp_wdata = 32'h0;
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!we) begin
            exp_lat = 3; exp_rd = 1; exp_wr = 0;
            exp_rdata = ref_load(ref_mem[idx], size, uns, addr);
        end else if (size == 2'd2) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            exp_wdata = wd;
        end else begin
            exp_lat = 3; exp_rd = 1; exp_wr = 1;
            exp_wdata = ref_store(ref_mem[idx], size, addr, wd);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        chk_eq("ready_at_req", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        lat = 0; nrd = 0; nwr = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            scramble_fields();
            if (rd_en) begin
                nrd++;
                chk_eq("rd_addr", rd_addr, addr >> 2);
            end
            if (wr_en) begin
                nwr++;
                chk_eq("wr_addr", wr_addr, addr >> 2);
                chk_eq("wr_data", wr_data, exp_wdata);
            end
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) chk_eq("resp_timeout", 32'h0, 32'h1);
        chk_eq("latency", lat, exp_lat);
        chk_eq("resp_err", {31'b0, resp_err}, {31'b0, mis});
        chk_eq("resp_rdata", resp_rdata, exp_rdata);
        chk_eq("rd_strobes", nrd, exp_rd);
        chk_eq("wr_strobes", nwr, exp_wr);
        if (we && !mis) ref_mem[idx] = exp_wdata;
    endtask

    initial begin
        logic [31:0] d;
        // Reset state and memory preload while reset is held.
        for (int i = 0; i < 16; i++) begin
            if (i == 4) bd_write(4'(i), 32'h8899_AABB);
            else if (i == 8) bd_write(4'(i), 32'h1122_3344);
            else bd_write(4'(i), $urandom);
        end
        @(negedge clk);
        chk_eq("rst_ready", {31'b0, req_ready}, 32'h0);
        chk_eq("rst_resp", {30'b0, resp_valid, resp_err}, 32'h0);
        chk_eq("rst_rdata", resp_rdata, 32'h0);
        chk_eq("rst_strobes", {30'b0, rd_en, wr_en}, 32'h0);
        chk_eq("rst_addrs", rd_addr | wr_addr | wr_data, 32'h0);
        rst = 1'b0;
        #1 chk_eq("ready_after_rst", {31'b0, req_ready}, 32'h1);

        // Directed cases.
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_txn(1'b1, 2'd0, 1'b0, 32'h21, 32'h5A);
        chk_eq("byte_store_word", ref_mem[8], 32'h1122_5A44);
        do_txn(1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h03, 32'hBEEF);
        do_txn(1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        do_txn(1'b1, 2'd3, 1'b0, 32'h08, 32'h1);

        // Reset in the read cycle of a sub-word store aborts it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk_eq("abort_rd_en", {31'b0, rd_en}, 32'h1);
        rst = 1'b1;
        #1 chk_eq("abort_rd_gated", {31'b0, rd_en}, 32'h0);
        @(negedge clk);
        chk_eq("abort_in_rst", {29'b0, req_ready, wr_en, resp_valid}, 32'h0);
        rst = 1'b0;
        #1 chk_eq("abort_ready", {31'b0, req_ready}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_eq("abort_quiet", {30'b0, wr_en, resp_valid}, 32'h0);
        end
        do_txn(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_0001);

        // Back-to-back: word store then word load with valid held high.
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        chk_eq("b2b_busy", {31'b0, req_ready}, 32'h0);
        chk_eq("b2b_wr", {30'b0, wr_en, resp_valid}, 32'h2);
        req_we = 1'b0; req_addr = 32'h30; req_unsigned = 1'b0;
        @(negedge clk);
        chk_eq("b2b_resp1", {30'b0, resp_valid, req_ready}, 32'h3);
        @(posedge clk);
        ref_mem[12] = d;
        @(negedge clk);
        req_valid = 1'b0;
        chk_eq("b2b_rd", {30'b0, rd_en, resp_valid}, 32'h2);
        @(negedge clk);
        chk_eq("b2b_cap", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        chk_eq("b2b_resp2", {31'b0, resp_valid}, 32'h1);
        chk_eq("b2b_rdata", resp_rdata, d);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 16; i++) chk_eq($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
